// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX scheduler and its round-robin picker.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first requester at or after rr_ptr, wrapping.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W:0]   slot;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        pick  = '0;
        slot  = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            slot = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (slot >= (IDX_W+1)'(N_REQ)) slot = slot - (IDX_W+1)'(N_REQ);
            cand = slot[IDX_W-1:0];
            if (!found && req[cand]) begin
                pick[cand] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any = |req;
    assign idx = IDX_W'(onehot2idx(8'(pick)));

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among N_REQ byte streams with round-robin, frame-locked arbitration.
//  state     | meaning
//  IDLE      | no owner; pick next requester from rr_ptr
//  LOAD      | owner granted; load its byte when core idle, count idle cycles while req low
//  WAIT_BUSY | byte loaded; wait for core busy (or guard expiry)
//  WAIT_DONE | core transmitting; wait for busy to fall
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int TIMEOUT    = 1024,
    parameter int BUSY_GUARD = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [DATA_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ack,
    output logic [N_REQ-1:0]        grant,
    output logic                    tx_load,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_busy,
    output logic                    err_timeout
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int GRD_W = $clog2(BUSY_GUARD + 1);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [GRD_W-1:0] GRD_MAX  = GRD_W'(BUSY_GUARD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d, ack_q, ack_d, pick;
    logic [IDX_W-1:0]  owner_q, owner_d, rr_ptr_q, rr_ptr_d, pick_idx, next_ptr;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [GRD_W-1:0]  guard_cnt_q, guard_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] data_arr [N_REQ];
    logic              last_q, last_d, load_q, load_d, err_q, err_d;
    logic              pick_any, byte_done;

    uart_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .pick   (pick),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Releasing owner drops to lowest priority for the next pick.
    assign next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        for (int i = 0; i < N_REQ; i++) data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        idle_cnt_d  = idle_cnt_q;
        guard_cnt_d = guard_cnt_q;
        data_d      = data_q;
        last_d      = last_q;
        ack_d       = '0;
        load_d      = 1'b0;
        err_d       = 1'b0;
        byte_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick;
                    owner_d = pick_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (req[owner_q] && !tx_busy) begin
                    load_d         = 1'b1;
                    ack_d[owner_q] = 1'b1;
                    data_d         = data_arr[owner_q];
                    last_d         = req_last[owner_q];
                    idle_cnt_d     = '0;
                    guard_cnt_d    = '0;
                    state_d        = WAIT_BUSY;
                end else if (!req[owner_q]) begin
                    if (idle_cnt_q >= IDLE_MAX) begin
                        err_d      = 1'b1;
                        grant_d    = '0;
                        rr_ptr_d   = next_ptr;
                        idle_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    end
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) state_d = WAIT_DONE;
                else if (guard_cnt_q == GRD_MAX) byte_done = 1'b1;
                else guard_cnt_d = guard_cnt_q + GRD_W'(1);
            end
            WAIT_DONE: begin
                if (!tx_busy) byte_done = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (byte_done) begin
            if (last_q) begin
                grant_d  = '0;
                rr_ptr_d = next_ptr;
                state_d  = IDLE;
            end else begin
                state_d  = LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            idle_cnt_q  <= '0;
            guard_cnt_q <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            ack_q       <= '0;
            load_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            idle_cnt_q  <= idle_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            data_q      <= data_d;
            last_q      <= last_d;
            ack_q       <= ack_d;
            load_q      <= load_d;
            err_q       <= err_d;
        end
    end

    assign grant       = grant_q;
    assign req_ack     = ack_q;
    assign tx_load     = load_q;
    assign tx_data     = data_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: latency, frame lock, round-robin order, timeout, reset, busy guard.
module tb_uart_tx_scheduler;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   req_last = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ack, grant;
    logic           tx_load, tx_busy, err_timeout;
    logic [7:0]     tx_data;

    int n_chk  = 0;
    int n_fail = 0;

    logic [8:0] fifo [N][16];
    logic [3:0] head [N];
    logic [3:0] tail [N];
    logic [7:0] log_data [32];
    logic [3:0] log_grant [32];
    int n_log = 0;
    int n_err = 0;
    int busy_len = 10;
    int busy_cnt = 0;
    int cyc;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.N_REQ(N), .TIMEOUT(16), .BUSY_GUARD(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ack     (req_ack),
        .grant       (grant),
        .tx_load     (tx_load),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .err_timeout (err_timeout)
    );

    // UART core model: busy for busy_len cycles starting the cycle after a load; 0 = tied low.
    always @(posedge clk or negedge rst) begin
        if (!rst) busy_cnt <= 0;
        else if (tx_load && busy_len != 0) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            req[i]             = (head[i] != tail[i]);
            req_data[8*i +: 8] = fifo[i][head[i]][7:0];
            req_last[i]        = fifo[i][head[i]][8];
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic last);
        fifo[i][tail[i]] = {last, d};
        tail[i] = tail[i] + 4'd1;
        refresh();
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            head[i] = '0;
            tail[i] = '0;
            for (int j = 0; j < 16; j++) fifo[i][j] = '0;
        end
        refresh();
        n_log = 0;
        n_err = 0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_loads(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (n_log < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(n_log >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while ((grant != '0 || req != '0) && k < budget) begin
            tick();
            k++;
        end
        chk(tag, {28'd0, grant}, 32'd0);
    endtask

    // Requester and monitor: pop on ack, log each load, count timeout pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < N; i++)
                    if (req_ack[i] && head[i] != tail[i]) head[i] = head[i] + 4'd1;
                if (tx_load && n_log < 32) begin
                    log_data[n_log]  = tx_data;
                    log_grant[n_log] = grant;
                    n_log++;
                end
                if (err_timeout) n_err++;
                refresh();
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = '0;
            tail[i] = '0;
        end
        #2;
        chk("reset_grant", {28'd0, grant}, 32'd0);
        chk("reset_tx_load", {31'd0, tx_load}, 32'd0);
        chk("reset_tx_data", {24'd0, tx_data}, 32'd0);

        // 1: single 3-byte frame from requester 0
        do_reset();
        busy_len = 10;
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b0);
        push(0, 8'h43, 1'b1);
        tick();
        chk("t1_grant_lat", {28'd0, grant}, 32'h1);
        chk("t1_no_early_load", {31'd0, tx_load}, 32'd0);
        tick();
        chk("t1_load_lat", {31'd0, tx_load}, 32'd1);
        chk("t1_first_data", {24'd0, tx_data}, 32'h41);
        wait_loads("t1_loads", 3, 200);
        for (int k = 0; k < 3; k++) begin
            chk("t1_data", {24'd0, log_data[k]}, 32'h41 + 32'(k));
            chk("t1_owner", {28'd0, log_grant[k]}, 32'h1);
        end
        cyc = 0;
        while (!tx_busy && cyc < 20) begin tick(); cyc++; end
        while (tx_busy && cyc < 40) begin tick(); cyc++; end
        chk("t1_grant_at_busy_fall", {28'd0, grant}, 32'h1);
        tick();
        chk("t1_release", {28'd0, grant}, 32'h0);

        // 2: requesters 0 and 2 together, no interleave
        do_reset();
        busy_len = 4;
        push(0, 8'hA0, 1'b0);
        push(0, 8'hA1, 1'b1);
        push(2, 8'hC0, 1'b0);
        push(2, 8'hC1, 1'b1);
        wait_loads("t2_loads", 4, 300);
        for (int k = 0; k < 4; k++) begin
            chk("t2_data", {24'd0, log_data[k]}, (k < 2) ? 32'hA0 + 32'(k) : 32'hC0 + 32'(k - 2));
            chk("t2_owner", {28'd0, log_grant[k]}, (k < 2) ? 32'h1 : 32'h4);
        end
        wait_idle("t2_idle", 100);

        // 3: all four hold single-byte frames
        do_reset();
        busy_len = 2;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push(i, 8'(16 * i + r), 1'b1);
        wait_loads("t3_loads", 8, 400);
        for (int k = 0; k < 8; k++) begin
            chk("t3_order", {28'd0, log_grant[k]}, 32'(1 << (k % 4)));
            chk("t3_data", {24'd0, log_data[k]}, 32'(16 * (k % 4) + k / 4));
        end
        wait_idle("t3_idle", 100);

        // 4: requester 1 stalls mid-frame; requester 2 pending
        do_reset();
        busy_len = 3;
        push(1, 8'h55, 1'b0);
        wait_loads("t4_first_load", 1, 20);
        push(2, 8'h66, 1'b1);
        cyc = 0;
        while (!tx_busy && cyc < 10) begin tick(); cyc++; end
        while (tx_busy && cyc < 20) begin tick(); cyc++; end
        cyc = 0;
        while (!err_timeout && cyc < 40) begin tick(); cyc++; end
        chk("t4_timeout_cycle", 32'(cyc), 32'd17);
        chk("t4_grant_released", {28'd0, grant}, 32'h0);
        chk("t4_err_count", 32'(n_err), 32'd1);
        tick();
        chk("t4_err_width", {31'd0, err_timeout}, 32'd0);
        chk("t4_next_grant", {28'd0, grant}, 32'h4);
        wait_loads("t4_second_load", 2, 50);
        chk("t4_next_data", {24'd0, log_data[1]}, 32'h66);
        wait_idle("t4_idle", 100);

        // 5: reset during WAIT_DONE of requester 3
        do_reset();
        busy_len = 10;
        push(3, 8'h77, 1'b0);
        push(3, 8'h78, 1'b1);
        wait_loads("t5_first_load", 1, 20);
        tick();
        tick();
        tick();
        chk("t5_grant_before", {28'd0, grant}, 32'h8);
        rst = 1'b0;
        #1;
        chk("t5_rst_grant", {28'd0, grant}, 32'h0);
        chk("t5_rst_load", {31'd0, tx_load}, 32'd0);
        chk("t5_rst_ack", {28'd0, req_ack}, 32'h0);
        chk("t5_rst_data", {24'd0, tx_data}, 32'h0);
        do_reset();
        push(2, 8'hA2, 1'b1);
        push(1, 8'h91, 1'b1);
        tick();
        chk("t5_first_grant", {28'd0, grant}, 32'h2);
        wait_idle("t5_idle", 200);

        // 6: tx_busy tied low; guard expiry advances each byte
        do_reset();
        busy_len = 0;
        push(0, 8'h81, 1'b0);
        push(0, 8'h82, 1'b1);
        wait_loads("t6_first_load", 1, 20);
        cyc = 0;
        while (n_log < 2 && cyc < 20) begin tick(); cyc++; end
        chk("t6_guard_spacing", 32'(cyc), 32'd4);
        chk("t6_second_data", {24'd0, log_data[1]}, 32'h82);
        cyc = 0;
        while (grant != '0 && cyc < 20) begin tick(); cyc++; end
        chk("t6_release_delay", 32'(cyc), 32'd3);
        chk("t6_load_count", 32'(n_log), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
